// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU mem-stage port, the external master port and the data RAM bus.
// The arbiter takes the master modport; the environment (pipeline, loader, RAM) takes slave.
interface dmem_arbiter_if;
    logic        cpu_dce;
    logic [31:0] cpu_daddr;
    logic [31:0] cpu_din;
    logic [3:0]  cpu_we;
    logic [3:0]  cpu_dre;
    logic        cpu_stall;
    logic [31:0] cpu_dout;
    logic        cpu_ack;

    logic        ext_req;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_we;
    logic        ext_gnt;
    logic [31:0] ext_rdata;
    logic        ext_ack;

    logic        mem_ce;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;

    modport master (
        input  cpu_dce, cpu_daddr, cpu_din, cpu_we, cpu_dre,
        output cpu_stall, cpu_dout, cpu_ack,
        input  ext_req, ext_addr, ext_wdata, ext_we,
        output ext_gnt, ext_rdata, ext_ack,
        output mem_ce, mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport slave (
        output cpu_dce, cpu_daddr, cpu_din, cpu_we, cpu_dre,
        input  cpu_stall, cpu_dout, cpu_ack,
        output ext_req, ext_addr, ext_wdata, ext_we,
        input  ext_gnt, ext_rdata, ext_ack,
        input  mem_ce, mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single-port data RAM between the CPU mem stage and an
// external master, using an IDLE/ACCESS/DONE sequencer with a fixed bus hold time.
module dmem_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic           cpu_clk_50M,
    input  logic           cpu_rst,
    dmem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OWN_CPU, OWN_EXT} owner_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t      state_reg, state_next;
    owner_t      owner_reg, owner_next;
    owner_t      last_reg, last_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [3:0]  we_reg, we_next;
    logic [3:0]  dre_reg, dre_next;
    logic [31:0] cpu_dout_reg, cpu_dout_next;
    logic [31:0] ext_rdata_reg, ext_rdata_next;
    logic [31:0] dre_mask;
    logic        pick_ext;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
        assign dre_mask[gi*8 +: 8] = {8{dre_reg[gi]}};
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_CPU;
            last_reg      <= OWN_EXT;
            cnt_reg       <= 4'd0;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            we_reg        <= 4'd0;
            dre_reg       <= 4'd0;
            cpu_dout_reg  <= 32'd0;
            ext_rdata_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            last_reg      <= last_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            we_reg        <= we_next;
            dre_reg       <= dre_next;
            cpu_dout_reg  <= cpu_dout_next;
            ext_rdata_reg <= ext_rdata_next;
        end
    end

    // On a tie the requester that was not served last wins.
    assign pick_ext = bus.ext_req && (!bus.cpu_dce || last_reg == OWN_CPU);

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        last_next      = last_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        we_next        = we_reg;
        dre_next       = dre_reg;
        cpu_dout_next  = cpu_dout_reg;
        ext_rdata_next = ext_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (bus.cpu_dce || bus.ext_req) begin
                    cnt_next   = 4'd1;
                    state_next = ACCESS;
                    if (pick_ext) begin
                        owner_next = OWN_EXT;
                        addr_next  = bus.ext_addr;
                        wdata_next = bus.ext_wdata;
                        we_next    = bus.ext_we;
                        dre_next   = 4'b1111;
                    end else begin
                        owner_next = OWN_CPU;
                        addr_next  = bus.cpu_daddr;
                        wdata_next = bus.cpu_din;
                        we_next    = bus.cpu_we;
                        dre_next   = bus.cpu_dre;
                    end
                end
            end
            ACCESS: begin
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == WAIT_LAST) begin
                    if (we_reg == 4'd0) begin
                        if (owner_reg == OWN_CPU) cpu_dout_next  = bus.mem_rdata & dre_mask;
                        else                      ext_rdata_next = bus.mem_rdata;
                    end
                    last_next  = owner_reg;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The RAM bus is only driven while an access is in flight.
    assign bus.mem_ce    = (state_reg == ACCESS);
    assign bus.mem_addr  = (state_reg == ACCESS) ? addr_reg  : 32'd0;
    assign bus.mem_wdata = (state_reg == ACCESS) ? wdata_reg : 32'd0;
    assign bus.mem_we    = (state_reg == ACCESS) ? we_reg    : 4'd0;

    assign bus.cpu_ack   = (state_reg == DONE) && (owner_reg == OWN_CPU);
    assign bus.ext_ack   = (state_reg == DONE) && (owner_reg == OWN_EXT);
    assign bus.ext_gnt   = (owner_reg == OWN_EXT) && (state_reg != IDLE);
    assign bus.cpu_stall = bus.cpu_dce && !bus.cpu_ack;
    assign bus.cpu_dout  = cpu_dout_reg;
    assign bus.ext_rdata = ext_rdata_reg;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: requesters push expected responses, a negedge
// monitor checks the RAM bus and the acks against a word-array memory model.
module tb_dmem_arbiter;
    localparam int W = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [31:0] exp;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if bus();
    dmem_arbiter_if bus3();

    dmem_arbiter #(.WAIT_CYCLES(W)) dut  (.cpu_clk_50M(clk), .cpu_rst(rst), .bus(bus));
    dmem_arbiter #(.WAIT_CYCLES(3)) dut3 (.cpu_clk_50M(clk), .cpu_rst(rst), .bus(bus3));

    // RAM device seen by the main DUT, with combinational read of the addressed word.
    logic [31:0] ram [64];
    logic [31:0] model [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'd0;

    assign bus.mem_rdata  = ram[bus.mem_addr[7:2]];
    assign bus3.mem_rdata = 32'hA500_0000 ^ 32'(cyc);

    always @(posedge clk) begin
        if (pl_en) ram[pl_idx] <= pl_val;
        else if (bus.mem_ce)
            for (int i = 0; i < 4; i++)
                if (bus.mem_we[i]) ram[bus.mem_addr[7:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end

    txn_t        cpu_q[$];
    txn_t        ext_q[$];
    logic [31:0] last_cpu_exp = 32'd0;
    logic [31:0] last_ext_exp = 32'd0;
    logic        mon_en = 1'b0;
    logic        log_en = 1'b0;
    int          ack_own[$];
    int          ack_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        for (int i = 0; i < 4; i++)
            if (w[i]) model[a[7:2]][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        model[idx] = val;
        pl_en = 1'b1; pl_idx = 6'(idx); pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge that ends the ack cycle.
    task automatic cpu_access(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] w, input logic [3:0] r);
        txn_t t;
        int   n;
        t.addr = a; t.wdata = d; t.we = w;
        if (w == 4'd0) begin
            t.exp = model[a[7:2]] & lane_mask(r);
            last_cpu_exp = t.exp;
        end else begin
            t.exp = last_cpu_exp;
            model_write(a, d, w);
        end
        cpu_q.push_back(t);
        bus.cpu_daddr = a; bus.cpu_din = d; bus.cpu_we = w; bus.cpu_dre = r; bus.cpu_dce = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.cpu_ack && n < 60);
        if (!bus.cpu_ack) chk("cpu_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.cpu_dce = 1'b0;
    endtask

    task automatic ext_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        txn_t t;
        int   n;
        t.addr = a; t.wdata = d; t.we = w;
        if (w == 4'd0) begin
            t.exp = model[a[7:2]];
            last_ext_exp = t.exp;
        end else begin
            t.exp = last_ext_exp;
            model_write(a, d, w);
        end
        ext_q.push_back(t);
        bus.ext_addr = a; bus.ext_wdata = d; bus.ext_we = w; bus.ext_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ext_ack && n < 60);
        if (!bus.ext_ack) chk("ext_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.ext_req = 1'b0;
    endtask

    // CPU uses words with addr[7]=0, EXT uses addr[7]=1, so their data never interact.
    task automatic cpu_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            logic [3:0]  w;
            int          g;
            a = $urandom; a[7] = 1'b0;
            w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            cpu_access(a, $urandom, w, 4'($urandom_range(1, 15)));
            g = $urandom_range(0, 3);
            if (g > 0) begin repeat (g) @(posedge clk); #1; end
        end
    endtask

    task automatic ext_random(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            logic [3:0]  w;
            int          g;
            a = $urandom; a[7] = 1'b1;
            w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            ext_access(a, $urandom, w);
            g = $urandom_range(0, 3);
            if (g > 0) begin repeat (g) @(posedge clk); #1; end
        end
    endtask

    // Monitor: RAM bus contents during ACCESS, ack data, bus hold time, grant and stall.
    int   run = 0;
    txn_t mt;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("cpu_stall", {31'd0, bus.cpu_stall}, {31'd0, bus.cpu_dce && !bus.cpu_ack});
            if (bus.mem_ce) begin
                run++;
                chk("ext_gnt_access", {31'd0, bus.ext_gnt}, {31'd0, bus.mem_addr[7]});
                if (bus.mem_addr[7] ? (ext_q.size() == 0) : (cpu_q.size() == 0)) begin
                    chk("access_without_request", 32'd0, 32'd1);
                end else begin
                    mt = bus.mem_addr[7] ? ext_q[0] : cpu_q[0];
                    chk("mem_addr", bus.mem_addr, mt.addr);
                    chk("mem_we", {28'd0, bus.mem_we}, {28'd0, mt.we});
                    chk("mem_wdata", bus.mem_wdata, mt.wdata);
                end
            end else begin
                if (bus.cpu_ack || bus.ext_ack) begin
                    chk("ack_exclusive", {31'd0, bus.cpu_ack && bus.ext_ack}, 32'd0);
                    chk("bus_hold_cycles", 32'(run), 32'(W));
                    chk("ext_gnt_done", {31'd0, bus.ext_gnt}, {31'd0, bus.ext_ack});
                    if (log_en) begin
                        ack_own.push_back(bus.ext_ack ? 1 : 0);
                        ack_cyc.push_back(cyc);
                    end
                    if (bus.cpu_ack) begin
                        if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 32'd0, 32'd1);
                        else begin mt = cpu_q.pop_front(); chk("cpu_dout", bus.cpu_dout, mt.exp); end
                    end else begin
                        if (ext_q.size() == 0) chk("ext_ack_unexpected", 32'd0, 32'd1);
                        else begin mt = ext_q.pop_front(); chk("ext_rdata", bus.ext_rdata, mt.exp); end
                    end
                end else begin
                    chk("ext_gnt_idle", {31'd0, bus.ext_gnt}, 32'd0);
                end
                run = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ce_n, t0, acks_seen;
        bus.cpu_dce = 1'b1; bus.cpu_daddr = 32'd0; bus.cpu_din = 32'd0;
        bus.cpu_we = 4'd0; bus.cpu_dre = 4'd0;
        bus.ext_req = 1'b1; bus.ext_addr = 32'd0; bus.ext_wdata = 32'd0; bus.ext_we = 4'd0;
        bus3.cpu_dce = 1'b0; bus3.cpu_daddr = 32'd0; bus3.cpu_din = 32'd0;
        bus3.cpu_we = 4'd0; bus3.cpu_dre = 4'd0;
        bus3.ext_req = 1'b0; bus3.ext_addr = 32'd0; bus3.ext_wdata = 32'd0; bus3.ext_we = 4'd0;
        rst = 1'b1;

        // Reset held with both requests asserted; fill the RAM meanwhile.
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        @(negedge clk);
        chk("rst_mem_ce", {31'd0, bus.mem_ce}, 32'd0);
        chk("rst_mem_we", {28'd0, bus.mem_we}, 32'd0);
        chk("rst_acks", {30'd0, bus.cpu_ack, bus.ext_ack}, 32'd0);
        chk("rst_ext_gnt", {31'd0, bus.ext_gnt}, 32'd0);
        chk("rst_cpu_stall", {31'd0, bus.cpu_stall}, 32'd1);
        @(posedge clk); #1;
        bus.cpu_dce = 1'b0; bus.ext_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // CPU lw with explicit stall/ack timing.
        preload(0, 32'hDEAD_BEEF);
        fork
            cpu_access(32'h100, 32'h0, 4'b0000, 4'b1111);
            begin
                @(negedge clk);
                chk("lw_stall_T", {31'd0, bus.cpu_stall}, 32'd1);
                @(negedge clk);
                chk("lw_stall_T1", {31'd0, bus.cpu_stall}, 32'd1);
                chk("lw_ce_T1", {31'd0, bus.mem_ce}, 32'd1);
                chk("lw_addr_T1", bus.mem_addr, 32'h100);
                @(negedge clk);
                chk("lw_stall_T2", {31'd0, bus.cpu_stall}, 32'd0);
                chk("lw_ack_T2", {31'd0, bus.cpu_ack}, 32'd1);
                chk("lw_dout_T2", bus.cpu_dout, 32'hDEAD_BEEF);
            end
        join

        // CPU sb: write leaves cpu_dout alone.
        cpu_access(32'h103, 32'h5555_5555, 4'b0001, 4'b0000);
        chk("sb_dout_hold", bus.cpu_dout, 32'hDEAD_BEEF);

        // CPU lb on lane 2.
        preload(16, 32'h1122_3344);
        cpu_access(32'h40, 32'h0, 4'b0000, 4'b0100);
        chk("lb_dout", bus.cpu_dout, 32'h0022_0000);

        // Both requesters held from reset release: strict alternation, CPU first.
        ack_own.delete(); ack_cyc.delete();
        last_cpu_exp = 32'd0; last_ext_exp = 32'd0;
        rst = 1'b1;
        log_en = 1'b1;
        fork
            begin
                cpu_access(32'h08, $urandom, 4'b0000, 4'b1111);
                cpu_access(32'h0C, $urandom, 4'b0000, 4'b1111);
            end
            begin
                ext_access(32'h80, $urandom, 4'b0000);
                ext_access(32'h84, $urandom, 4'b0000);
            end
            begin
                repeat (2) @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        log_en = 1'b0;
        chk("rr_ack_count", 32'(ack_own.size()), 32'd4);
        if (ack_own.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("rr_owner_%0d", i), 32'(ack_own[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) chk($sformatf("rr_spacing_%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end

        // Randomized concurrent traffic.
        fork
            cpu_random(40);
            ext_random(40);
        join
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("ext_q_drained", 32'(ext_q.size()), 32'd0);

        // WAIT_CYCLES=3 instance: RAM data changes every cycle, third ACCESS cycle wins.
        @(posedge clk); #1;
        t0 = cyc;
        bus3.cpu_daddr = 32'h44; bus3.cpu_we = 4'd0; bus3.cpu_dre = 4'b1111; bus3.cpu_dce = 1'b1;
        n = 0; ce_n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus3.mem_ce) ce_n++;
            if (bus3.cpu_ack) break;
            n++;
        end
        chk("w3_latency", 32'(n), 32'd4);
        chk("w3_ce_cycles", 32'(ce_n), 32'd3);
        chk("w3_dout", bus3.cpu_dout, 32'hA500_0000 ^ 32'(t0 + 3));
        @(posedge clk); #1;
        bus3.cpu_dce = 1'b0;

        // Reset in the middle of an ACCESS: bus drops at once and no ack ever follows.
        mon_en = 1'b0;
        @(posedge clk); #1;
        bus.cpu_daddr = 32'h10; bus.cpu_we = 4'd0; bus.cpu_dre = 4'b1111; bus.cpu_dce = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_ce_before", {31'd0, bus.mem_ce}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_ce_same_cycle", {31'd0, bus.mem_ce}, 32'd0);
        chk("abort_stall_in_reset", {31'd0, bus.cpu_stall}, 32'd1);
        @(posedge clk); #1;
        bus.cpu_dce = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        acks_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.ext_ack) acks_seen++;
        end
        chk("abort_no_ack", 32'(acks_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port synchronous data memory between two requesters: the pipeline mem stage (CPU port) and an external master (EXT port, e.g. program loader or debug).
- Runs a multi-cycle access FSM with a configurable wait count.
- Stalls the pipeline until the CPU access completes.
- Sits between the mem stage outputs (dce/daddr/din/we/dre) and the data RAM.

Parameters:
WAIT_CYCLES, 1, cycles the memory bus is driven per access; mem_rdata is sampled at the end of the last one (legal range 1..15)

Ports:
cpu_clk_50M  in  1  clock, all flops on rising edge
cpu_rst  in  1  asynchronous reset, active-high
cpu_dce  in  1  CPU access request, held stable while cpu_stall=1
cpu_daddr  in  32  CPU byte address
cpu_din  in  32  CPU write data (already lane-replicated/byte-swapped)
cpu_we  in  4  CPU byte write enables; 0000 means read
cpu_dre  in  4  CPU byte read enables
cpu_stall  out  1  pipeline freeze request
cpu_dout  out  32  CPU read data, masked by the latched dre
cpu_ack  out  1  CPU access-complete pulse
ext_req  in  1  EXT request, held until ext_ack
ext_addr  in  32  EXT address
ext_wdata  in  32  EXT write data
ext_we  in  4  EXT byte write enables; 0000 means read
ext_gnt  out  1  EXT owns the memory
ext_rdata  out  32  EXT read data, full word
ext_ack  out  1  EXT access-complete pulse
mem_ce  out  1  RAM chip enable
mem_addr  out  32  RAM address
mem_wdata  out  32  RAM write data
mem_we  out  4  RAM byte write enables
mem_rdata  in  32  RAM read data

Behaviour:
- States: IDLE, ACCESS, DONE. Registers: owner (CPU/EXT), last (last owner served), cnt (4 bits), latched addr/wdata/we/dre, cpu_dout reg, ext_rdata reg.
- Reset values: state=IDLE, last=EXT (so the CPU wins the first tie), cnt=0, all latches and data regs 0. mem_ce, mem_we, acks, ext_gnt = 0. cpu_stall = cpu_dce (combinational).
- IDLE, no requests: remain in IDLE.
- IDLE, one requester asserting: grant it. Latch its addr/wdata/we/dre, set owner, cnt<=1, go to ACCESS.
- IDLE, both requesting: grant the one that is not equal to last (round-robin).
- ACCESS:
  - mem_ce=1; mem_addr/mem_wdata/mem_we driven from the latches. Bus is 0 in every other state.
  - cnt increments each cycle.
  - At the edge ending the cycle where cnt==WAIT_CYCLES: capture mem_rdata into the owner's data reg (reads only; write captures nothing), last<=owner, go to DONE.
- DONE: owner's ack=1 for exactly one cycle; next state IDLE. Requests are not evaluated in DONE, giving a one-cycle bubble between accesses.
- Latency, grant cycle T to ack: WAIT_CYCLES+1 cycles. With the default, a CPU access stalls 2 cycles and acks in cycle T+2.
- cpu_stall = cpu_dce AND NOT (state==DONE AND owner==CPU). Combinational; drops in the ack cycle so the pipeline advances.
- ext_gnt = (owner==EXT) AND state!=IDLE.
- cpu_dout masking, byte lane i = dre bit: dre[3] covers bits[31:24] … dre[0] covers bits[7:0]. Unselected lanes are 0. cpu_dout holds its value until the next CPU read capture.
- Writes: mem_we stays asserted for all WAIT_CYCLES cycles with constant data; repeated writes are idempotent.
- Requester drops its request mid-access: the access still completes and acks. It is the requester's protocol error, with no effect on the FSM.
- Reset asserted mid-ACCESS or mid-DONE: all outputs clear asynchronously in the same cycle. The aborted access is never acked. The FSM restarts in IDLE once reset releases.

Test Plan:
1. Reset: hold cpu_rst with cpu_dce=1 and ext_req=1 -> mem_ce=0, mem_we=0000, acks=0, ext_gnt=0, cpu_stall=1. Assert cpu_rst during ACCESS -> mem_ce falls in the same cycle, no ack follows.
2. CPU lw (default WAIT_CYCLES), daddr=0x100, dre=1111, RAM returns 0xDEADBEEF -> mem_ce=1 with mem_addr=0x100 for 1 cycle. cpu_stall high in T and T+1, low in T+2. cpu_ack=1 and cpu_dout=0xDEADBEEF in T+2.
3. CPU sb, daddr=0x103, we=0001, din=0x55555555 -> mem_we=0001, mem_addr=0x103, mem_wdata=0x55555555 during ACCESS. cpu_ack pulses once. cpu_dout is unchanged.
4. CPU lb, dre=0100, RAM word 0x11223344 -> cpu_dout=0x00220000.
5. cpu_dce and ext_req held continuously from reset release -> grant order CPU, EXT, CPU, EXT. One idle bubble between accesses. ext_gnt high only during EXT-owned ACCESS/DONE. EXT reads return ext_rdata equal to the RAM word.
6. WAIT_CYCLES=3, RAM model changes mem_rdata every cycle -> only the value from the third ACCESS cycle is captured. cpu_ack arrives 4 cycles after grant.
